// File: rtl/alu_issue_stage.sv
// ============================================================================
// Module   : alu_issue_stage
// Brief    : ALU execute stage with E/R pipeline registers, valid/ready
//            handshake, three-level operand forwarding and synchronous flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_issue_stage #(
    parameter int WIDTH = 16,
    parameter int RBITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_rs_val,
    input  logic [WIDTH-1:0] in_rt_val,
    input  logic [RBITS-1:0] in_rs,
    input  logic [RBITS-1:0] in_rt,
    input  logic [WIDTH-1:0] in_imm,
    input  logic             in_use_imm,
    input  logic [3:0]       in_shamt,
    input  logic [1:0]       in_op,
    input  logic             in_sub,
    input  logic             in_ari,
    input  logic             in_lef,
    input  logic [RBITS-1:0] in_rd,
    input  logic             in_wen,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_shamt,
    output logic [1:0]       alu_op,
    output logic             alu_sub,
    output logic             alu_ari,
    output logic             alu_lef,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_zero,
    input  logic             wb_wen,
    input  logic [RBITS-1:0] wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic [RBITS-1:0] out_rd,
    output logic             out_wen
);

    localparam logic [RBITS-1:0] C_R0 = '0;

    // E register
    logic             r_e_valid;
    logic [WIDTH-1:0] r_e_a;
    logic [WIDTH-1:0] r_e_b;
    logic [3:0]       r_e_shamt;
    logic [1:0]       r_e_op;
    logic             r_e_sub;
    logic             r_e_ari;
    logic             r_e_lef;
    logic [RBITS-1:0] r_e_rd;
    logic             r_e_wen;

    // R register
    logic             r_r_valid;
    logic [WIDTH-1:0] r_r_result;
    logic             r_r_zero;
    logic [RBITS-1:0] r_r_rd;
    logic             r_r_wen;

    logic             w_r_take;
    logic             w_e_adv;
    logic             w_accept;
    logic [WIDTH-1:0] w_a_fwd;
    logic [WIDTH-1:0] w_b_fwd;

    // Youngest producer wins; register 0 is hard-wired to zero.
    function automatic logic [WIDTH-1:0] fwd_sel(
        input logic [RBITS-1:0] idx,
        input logic [WIDTH-1:0] rf_val,
        input logic             e_hit_en,
        input logic [RBITS-1:0] e_rd,
        input logic [WIDTH-1:0] e_val,
        input logic             r_hit_en,
        input logic [RBITS-1:0] r_rd,
        input logic [WIDTH-1:0] r_val,
        input logic             w_hit_en,
        input logic [RBITS-1:0] w_rd,
        input logic [WIDTH-1:0] w_val
    );
        logic [WIDTH-1:0] v;
        if (idx == C_R0)                       v = '0;
        else if (e_hit_en && (e_rd == idx))    v = e_val;
        else if (r_hit_en && (r_rd == idx))    v = r_val;
        else if (w_hit_en && (w_rd == idx))    v = w_val;
        else                                   v = rf_val;
        return v;
    endfunction

    assign w_r_take = !r_r_valid || out_ready;
    assign w_e_adv  = r_e_valid && w_r_take;
    // A flushed instruction is swallowed, so the stage is always ready then.
    assign in_ready = flush || !r_e_valid || w_e_adv;
    assign w_accept = in_valid && in_ready && !flush;

    always_comb begin
        w_a_fwd = fwd_sel(in_rs, in_rs_val,
                          r_e_valid && r_e_wen, r_e_rd, alu_c,
                          r_r_valid && r_r_wen, r_r_rd, r_r_result,
                          wb_wen, wb_rd, wb_data);
        w_b_fwd = in_imm;
        if (!in_use_imm) begin
            w_b_fwd = fwd_sel(in_rt, in_rt_val,
                              r_e_valid && r_e_wen, r_e_rd, alu_c,
                              r_r_valid && r_r_wen, r_r_rd, r_r_result,
                              wb_wen, wb_rd, wb_data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e_valid <= 1'b0;
            r_e_a     <= '0;
            r_e_b     <= '0;
            r_e_shamt <= '0;
            r_e_op    <= '0;
            r_e_sub   <= 1'b0;
            r_e_ari   <= 1'b0;
            r_e_lef   <= 1'b0;
            r_e_rd    <= '0;
            r_e_wen   <= 1'b0;
        end else if (flush) begin
            r_e_valid <= 1'b0;
        end else if (w_accept) begin
            r_e_valid <= 1'b1;
            r_e_a     <= w_a_fwd;
            r_e_b     <= w_b_fwd;
            r_e_shamt <= in_shamt;
            r_e_op    <= in_op;
            r_e_sub   <= in_sub;
            r_e_ari   <= in_ari;
            r_e_lef   <= in_lef;
            r_e_rd    <= in_rd;
            r_e_wen   <= in_wen;
        end else if (w_e_adv) begin
            r_e_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r_valid  <= 1'b0;
            r_r_result <= '0;
            r_r_zero   <= 1'b0;
            r_r_rd     <= '0;
            r_r_wen    <= 1'b0;
        end else if (flush) begin
            r_r_valid  <= 1'b0;
        end else if (w_e_adv) begin
            r_r_valid  <= 1'b1;
            r_r_result <= alu_c;
            r_r_zero   <= alu_zero;
            r_r_rd     <= r_e_rd;
            r_r_wen    <= r_e_wen;
        end else if (out_ready) begin
            r_r_valid  <= 1'b0;
        end
    end

    assign alu_a      = r_e_a;
    assign alu_b      = r_e_b;
    assign alu_shamt  = r_e_shamt;
    assign alu_op     = r_e_op;
    assign alu_sub    = r_e_sub;
    assign alu_ari    = r_e_ari;
    assign alu_lef    = r_e_lef;

    assign out_valid  = r_r_valid;
    assign out_result = r_r_result;
    assign out_zero   = r_r_zero;
    assign out_rd     = r_r_rd;
    assign out_wen    = r_r_wen;

endmodule

`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Execute-stage wrapper around the 16-bit ALU.
- Registers decoded operands and control into an execute (E) register that drives the ALU inputs directly.
- Captures ALU result and zero flag into a result (R) register for the writeback stage.
- Provides valid/ready handshaking, three-level operand forwarding and a synchronous flush. Sits between the decode stage and the register-file writeback stage.

Parameters:
WIDTH, 16, datapath width; must match the ALU.
RBITS, 3, register index width (8 registers; register 0 reads as zero).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous kill of E and R contents
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
in_rs_val  in  WIDTH  register-file value of rs
in_rt_val  in  WIDTH  register-file value of rt
in_rs  in  RBITS  source A index
in_rt  in  RBITS  source B index
in_imm  in  WIDTH  immediate
in_use_imm  in  1  B = in_imm instead of rt
in_shamt  in  4  shift amount
in_op  in  2  ALU op (0 add/sub, 1 nand, 2 slt, 3 shift)
in_sub  in  1  subtract select
in_ari  in  1  arithmetic-shift select
in_lef  in  1  left-shift select
in_rd  in  RBITS  destination index
in_wen  in  1  instruction writes rd
alu_a, alu_b  out  WIDTH  ALU operands (from E)
alu_shamt  out  4  from E
alu_op  out  2  from E
alu_sub, alu_ari, alu_lef  out  1  from E
alu_c  in  WIDTH  ALU result
alu_zero  in  1  ALU zero flag
wb_wen  in  1  writeback commits this cycle
wb_rd  in  RBITS  writeback index
wb_data  in  WIDTH  writeback value
out_valid  out  1  R holds a result
out_ready  in  1  writeback accepts R
out_result  out  WIDTH  registered alu_c
out_zero  out  1  registered alu_zero
out_rd  out  RBITS  destination index
out_wen  out  1  write enable

Behaviour:
- Reset (async, rst=1): E and R valid = 0. All E/R data and control registers = 0. All outputs = 0 except in_ready = 1.
- r_take = !r_valid || out_ready.
- e_adv = e_valid && r_take.
- in_ready = !e_valid || e_adv. This path is combinational and has no dependency on in_valid.
- Accept: an instruction is accepted when in_valid && in_ready at a rising edge. It loads E and sets e_valid=1.
- E hold: if e_valid && !e_adv, E holds every field and the alu_* outputs are stable.
- E to R transfer: on e_adv, R loads alu_c, alu_zero, e_rd and e_wen, and sets r_valid=1.
- E drain: if e_adv and no accept in the same cycle, e_valid=0.
- R drain: if out_ready && r_valid and no e_adv, r_valid=0.
- R hold: out_valid stays asserted and R is stable until out_ready is asserted.
- Latency: accept at edge N gives alu_* valid in cycle N+1 and out_valid in cycle N+2. Sustained throughput is one instruction per cycle when out_ready=1.
- Operand A forwarding (priority high to low, applied at accept):
  1. e_valid && e_wen && e_rd==in_rs → alu_c
  2. r_valid && out_wen && out_rd==in_rs → out_result
  3. wb_wen && wb_rd==in_rs → wb_data
  4. otherwise in_rs_val
- Operand A, register 0: if in_rs==0, A=0 regardless of any forward.
- Operand B: same forwarding on in_rt. in_use_imm=1 overrides B with in_imm and no forwarding applies.
- Flush: next edge clears e_valid and r_valid; data registers are don't-care.
- Flush with in_valid in the same cycle: in_ready=1, and the instruction is consumed and discarded, not loaded.
- Flush has priority over every other update.
- Reset asserted mid-operation: immediate clear regardless of clk. No partial result is ever presented after deassertion.
- Arithmetic: all operands are WIDTH bits and there are no width changes. This stage computes nothing beyond the operand muxes.

Test Plan:
1. Reset, then one add: rs_val=0x0005, rt_val=0x0003, op=0, sub=0, out_ready=1 → alu_a=5, alu_b=3 on cycle 1; out_result=0x0008, out_zero=0, out_valid on cycle 2, then deasserts.
2. Back-to-back forward: r1←0x0010+0x0001 then r2←r1 - 0x0011 (in_rs=1, stale rs_val=0) → second alu_a=0x0011 from the E forward; out_result=0x0000, out_zero=1.
3. Backpressure: out_ready=0 with 3 instructions offered → out_valid=1 with R stable, E full, in_ready=0 from cycle 2; raise out_ready → results emerge in order, one per cycle.
4. Priority: E, R and wb all target r3 with distinct values 0xAAAA, 0xBBBB and 0xCCCC; next instruction reads r3 → alu_a=E value. Same test with in_rs=0 → alu_a=0.
5. Flush while E and R are full and in_valid=1 → next cycle out_valid=0, e_valid=0, no output from any of the three instructions.
6. Assert rst asynchronously mid-stream → outputs zero immediately and in_ready=1; the first result after release comes only from a new accept.
